// File: rtl/text_ram_pkg.sv
// ============================================================================
// Module : text_ram_pkg
// Brief  : Shared types and defaults for the text RAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package text_ram_pkg;

  localparam int ADDR_W           = 10;
  localparam int DATA_W           = 32;
  localparam int STRB_W           = DATA_W / 8;
  localparam int DEF_DEPTH        = 601;
  localparam int DEF_CTRL_ADDR    = 600;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DISP = 2'd2
  } grant_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return int'({{(32-ADDR_W){1'b0}}, addr}) < depth;
  endfunction

endpackage

`default_nettype wire

// File: rtl/text_arb_starve_cnt.sv
// ============================================================================
// Module : text_arb_starve_cnt
// Brief  : Saturating count of display grants taken while the CPU waits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_arb_starve_cnt
  import text_ram_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic          at_limit_o,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign at_limit_o = (count_q == CW'(LIMIT));
  assign count_o    = count_q;

  // Clear has priority; increments stop once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !at_limit_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/text_ram_arbiter.sv
// ============================================================================
// Module : text_ram_arbiter
// Brief  : Two-port (CPU / display) arbiter onto a single text RAM, one
//          access per IDLE->ISSUE->WAIT->RESP pass, display-priority with
//          CPU starvation guard. Macro TEXT_ARB_CTRL_SHADOW_EN enables the
//          ctrl_reg shadow of the colour control word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module text_ram_arbiter
  import text_ram_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int CTRL_ADDR    = DEF_CTRL_ADDR,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [STRB_W-1:0] cpu_wstrb,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [STRB_W-1:0] ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ctrl_reg
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  state_t            state_q;
  grant_t            gnt_q;
  logic              acc_we_q;
  logic              acc_ok_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [STRB_W-1:0] ram_be_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_rdata_q;

  logic              w_idle;
  logic              w_at_limit;
  logic              w_cpu_win;
  logic              w_disp_win;
  logic              w_cpu_ok;
  logic              w_disp_ok;
  logic              w_ctrl_hit;
  logic [CNT_W-1:0]  w_starve_cnt;

  assign w_idle     = (state_q == IDLE);
  assign w_cpu_win  = w_idle && cpu_req && (!disp_req || w_at_limit);
  assign w_disp_win = w_idle && disp_req && !w_cpu_win;
  assign w_cpu_ok   = addr_in_range(cpu_addr, DEPTH);
  assign w_disp_ok  = addr_in_range(disp_addr, DEPTH);
  assign w_ctrl_hit = (cpu_addr == ADDR_W'(CTRL_ADDR));

  text_arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CW    (CNT_W)
  ) u_starve (
    .clk_i      (axi_aclk),
    .rst_ni     (axi_aresetn),
    .inc_i      (w_disp_win && cpu_req),
    .clr_i      (w_cpu_win || (w_idle && !cpu_req)),
    .at_limit_o (w_at_limit),
    .count_o    (w_starve_cnt)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= IDLE;
      gnt_q        <= GNT_NONE;
      acc_we_q     <= 1'b0;
      acc_ok_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_be_q     <= '0;
      ram_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_cpu_win) begin
            gnt_q       <= GNT_CPU;
            acc_we_q    <= cpu_we;
            acc_ok_q    <= w_cpu_ok;
            ram_addr_q  <= cpu_addr;
            ram_we_q    <= cpu_we && w_cpu_ok;
            ram_be_q    <= (cpu_we && w_cpu_ok) ? cpu_wstrb : '0;
            ram_wdata_q <= cpu_wdata;
            state_q     <= ISSUE;
          end else if (w_disp_win) begin
            gnt_q       <= GNT_DISP;
            acc_we_q    <= 1'b0;
            acc_ok_q    <= w_disp_ok;
            ram_addr_q  <= disp_addr;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          ram_we_q <= 1'b0;
          ram_be_q <= '0;
          state_q  <= WAIT;
        end
        WAIT: begin
          // Out-of-range reads return zero rather than whatever the RAM aliases to.
          if (gnt_q == GNT_CPU) begin
            cpu_ack_q <= 1'b1;
            if (!acc_we_q) begin
              cpu_rdata_q <= acc_ok_q ? ram_rdata : '0;
            end
          end else if (gnt_q == GNT_DISP) begin
            disp_valid_q <= 1'b1;
            disp_rdata_q <= acc_ok_q ? ram_rdata : '0;
          end
          state_q <= RESP;
        end
        RESP: begin
          cpu_ack_q    <= 1'b0;
          disp_valid_q <= 1'b0;
          gnt_q        <= GNT_NONE;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_be     = ram_be_q;
  assign ram_wdata  = ram_wdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_rdata = disp_rdata_q;

`ifdef TEXT_ARB_CTRL_SHADOW_EN
  logic [DATA_W-1:0] ctrl_q;

  // Shadow follows the RAM write lane-for-lane, visible in the ISSUE cycle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      ctrl_q <= '0;
    end else if (w_cpu_win && cpu_we && w_cpu_ok && w_ctrl_hit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (cpu_wstrb[b]) begin
          ctrl_q[8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ctrl_reg = ctrl_q;
`else
  logic w_unused_ctrl_hit;
  assign w_unused_ctrl_hit = w_ctrl_hit;
  assign ctrl_reg          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_text_ram_arbiter.sv
// ============================================================================
// Module : tb_text_ram_arbiter
// Brief  : Self-checking bench for text_ram_arbiter with a behavioural RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_text_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        disp_req;
  logic [9:0]  disp_addr;
  logic        disp_valid;
  logic [31:0] disp_rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] ctrl_reg;

  text_ram_arbiter dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_rdata  (disp_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_be      (ram_be),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ctrl_reg    (ctrl_reg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM, 1024 words so out-of-range addresses alias to real data.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    logic [31:0] old;
    old = mem[ram_addr];
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
    ram_rdata <= old;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] cpu_q [$];
  logic [31:0] disp_q [$];
  logic [31:0] cpu_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: each response pulse pops the expectation pushed at request time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ack) begin
        if (cpu_q.size() == 0) check("cpu_ack_unexpected", {31'b0, cpu_ack}, 32'h0);
        else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (disp_valid) begin
        if (disp_q.size() == 0) check("disp_valid_unexpected", {31'b0, disp_valid}, 32'h0);
        else check("disp_rdata", disp_rdata, disp_q.pop_front());
      end
    end
  end

  typedef struct {
    bit          is_cpu;
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  task automatic run_access(input vec_t v, input bit chk_ctrl, input logic [31:0] exp_ctrl);
    bit   got;
    bit   ok;
    bit   exp_we;
    ok     = (v.addr < 10'd601);
    exp_we = v.is_cpu && v.we && ok;
    @(posedge clk); #1;
    if (v.is_cpu) begin
      if (!v.we) cpu_hold = v.exp;
      cpu_q.push_back(cpu_hold);
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr;
      cpu_wdata = v.wdata; cpu_wstrb = v.wstrb;
    end else begin
      disp_q.push_back(v.exp);
      disp_req = 1'b1; disp_addr = v.addr;
    end
    got = 1'b0;
    for (int n = 1; n <= 12 && !got; n++) begin
      @(negedge clk);
      if (n == 2) begin
        check("ram_addr", {22'b0, ram_addr}, {22'b0, v.addr});
        check("ram_we_issue", {31'b0, ram_we}, {31'b0, exp_we});
        check("ram_be_issue", {28'b0, ram_be}, exp_we ? {28'b0, v.wstrb} : 32'h0);
        if (exp_we) check("ram_wdata", ram_wdata, v.wdata);
        if (chk_ctrl) check("ctrl_reg", ctrl_reg, exp_ctrl);
      end
      if (n == 3) check("ram_we_after", {27'b0, ram_be, ram_we}, 32'h0);
      if (v.is_cpu ? cpu_ack : disp_valid) begin
        got = 1'b1;
        check("latency", n, 4);
        cpu_req = 1'b0;
        disp_req = 1'b0;
      end
    end
    check("resp_timeout", {31'b0, got}, 32'h1);
  endtask

  vec_t vecs [13];
  logic [31:0] exp_ctrl_w;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    cpu_wstrb = '0; disp_req = 0; disp_addr = '0; cpu_hold = '0;

    vecs[0]  = '{1'b1, 1'b1, 10'd5,    32'h01020304, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 10'd5,    32'h0,        4'h0, 32'h01020304};
    vecs[2]  = '{1'b1, 1'b1, 10'd6,    32'hAABBCCDD, 4'h5, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 10'd6,    32'h0,        4'h0, 32'h10BB00DD};
    vecs[4]  = '{1'b0, 1'b0, 10'd600,  32'h0,        4'h0, 32'h10000258};
    vecs[5]  = '{1'b1, 1'b0, 10'd700,  32'h0,        4'h0, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 10'd700,  32'h11223344, 4'hF, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 10'd1023, 32'h0,        4'h0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 10'd0,    32'h0,        4'h0, 32'h10000000};
    vecs[9]  = '{1'b1, 1'b0, 10'd600,  32'h0,        4'h0, 32'h10000258};
    vecs[10] = '{1'b1, 1'b1, 10'd1,    32'hFFFFFFFF, 4'h8, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 10'd1,    32'h0,        4'h0, 32'hFF000001};
    vecs[12] = '{1'b1, 1'b0, 10'd700,  32'h0,        4'h0, 32'h0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {cpu_rdata | disp_rdata | ram_wdata | ctrl_reg},  32'h0);
    check("reset_ctl", {16'b0, ram_addr, ram_be, ram_we, cpu_ack, disp_valid}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_access(vecs[i], 1'b0, 32'h0);
    check("mem700_untouched", mem[700], 32'h100002BC);

    // Starvation: display re-requests back-to-back while the CPU waits.
    begin
      int  dcount;
      bit  done;
      for (int i = 0; i < 8; i++) disp_q.push_back(32'h10000008);
      cpu_hold = 32'h10000007;
      cpu_q.push_back(cpu_hold);
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd7;
      disp_req = 1'b1; disp_addr = 10'd8;
      dcount = 0; done = 1'b0;
      for (int n = 0; n < 100 && !done; n++) begin
        @(negedge clk);
        if (disp_valid) dcount++;
        if (cpu_ack) begin
          done = 1'b1;
          cpu_req = 1'b0;
          disp_req = 1'b0;
        end
      end
      check("starve_done", {31'b0, done}, 32'h1);
      check("starve_disp_grants", dcount, 8);
      check("starve_cnt_cleared", {28'b0, dut.u_starve.count_o}, 32'h0);
    end

    // Reset in the middle of a read (WAIT state).
    begin
      bit ack_seen;
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd9;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_data", cpu_rdata | disp_rdata | ram_wdata | ctrl_reg, 32'h0);
      check("midrst_ctl", {16'b0, ram_addr, ram_be, ram_we, cpu_ack, disp_valid}, 32'h0);
      cpu_req = 1'b0;
      cpu_hold = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ack_seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (cpu_ack) ack_seen = 1'b1;
      end
      check("midrst_no_ack", {31'b0, ack_seen}, 32'h0);
      run_access('{1'b1, 1'b0, 10'd9, 32'h0, 4'h0, 32'h10000009}, 1'b0, 32'h0);
    end

`ifdef TEXT_ARB_CTRL_SHADOW_EN
    exp_ctrl_w = 32'h0000CDEF;
`else
    exp_ctrl_w = 32'h0;
`endif
    run_access('{1'b1, 1'b1, 10'd600, 32'h00ABCDEF, 4'h3, 32'h0}, 1'b1, exp_ctrl_w);
    check("ctrl_reg_after", ctrl_reg, exp_ctrl_w);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", cpu_q.size() + disp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
